// File: rtl/pe_ctrl_pkg.sv
// Shared types for the PE array sequencer: FSM states and precision encodings.
package pe_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        COMPUTE,
        WAIT,
        DRAIN,
        DONE
    } state_t;

    // 2'b11 is reserved and is forwarded to pe_array without interpretation.
    localparam logic [1:0] PREC_INT8 = 2'b00;
    localparam logic [1:0] PREC_INT4 = 2'b01;
    localparam logic [1:0] PREC_INT2 = 2'b10;

endpackage

// File: rtl/skew_mask_gen.sv
// Skewed feed-enable mask: lane l is active for t in [l, l + k_len).
module skew_mask_gen #(
    parameter int LANES   = 2,
    parameter int K_WIDTH = 8
) (
    input  logic [K_WIDTH:0]   t,
    input  logic [K_WIDTH-1:0] k_len,
    output logic [LANES-1:0]   mask
);

    // Wide enough that lane + k_len never wraps.
    localparam int CW = K_WIDTH + 2 + $clog2(LANES + 1);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [CW-1:0] t_ext;
        logic [CW-1:0] lo;
        logic [CW-1:0] hi;

        assign t_ext   = CW'(t);
        assign lo      = CW'(l);
        assign hi      = CW'(l) + CW'(k_len);
        assign mask[l] = (t_ext >= lo) && (t_ext < hi);
    end

endmodule

// File: rtl/pe_array_ctrl.sv
// Sequencer for the MxN PE array: clear, skewed operand feed, pipeline wait,
// then a row-major drain of all results followed by a done pulse.
module pe_array_ctrl
    import pe_ctrl_pkg::*;
#(
    parameter int M       = 2,
    parameter int N       = 2,
    parameter int K_WIDTH = 8,
    parameter int PE_LAT  = 1,
    parameter int SEL_W   = (M * N > 1) ? $clog2(M * N) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [K_WIDTH-1:0] k_len,
    input  logic [1:0]         prec_in,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic               pe_clear,
    output logic               pe_en,
    output logic [1:0]         precision_mode,
    output logic [K_WIDTH:0]   step,
    output logic [M-1:0]       row_en,
    output logic [N-1:0]       col_en,
    output logic [SEL_W-1:0]   drain_sel,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam int LAT_W = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;
    localparam logic [LAT_W-1:0]   LAT_LAST = LAT_W'(PE_LAT - 1);
    localparam logic [SEL_W-1:0]   SEL_LAST = SEL_W'(M * N - 1);
    localparam logic [SEL_W-1:0]   SEL_ONE  = SEL_W'(1);
    localparam logic [K_WIDTH:0]   STEP_ONE = (K_WIDTH + 1)'(1);
    localparam logic [K_WIDTH:0]   SKEW_M1  = (K_WIDTH + 1)'(M + N - 3);

    state_t             state;
    logic [K_WIDTH-1:0] k_len_q;
    logic [LAT_W-1:0]   lat_cnt;
    logic [K_WIDTH:0]   last_t;
    logic [K_WIDTH:0]   mask_t;
    logic [M-1:0]       row_mask;
    logic [N-1:0]       col_mask;

    // Masks are evaluated for the step about to be presented so row_en/col_en stay registered.
    assign mask_t = (state == COMPUTE) ? step + STEP_ONE : '0;
    assign last_t = {1'b0, k_len_q} + SKEW_M1;

    skew_mask_gen #(.LANES(M), .K_WIDTH(K_WIDTH)) u_row_mask (
        .t     (mask_t),
        .k_len (k_len_q),
        .mask  (row_mask)
    );

    skew_mask_gen #(.LANES(N), .K_WIDTH(K_WIDTH)) u_col_mask (
        .t     (mask_t),
        .k_len (k_len_q),
        .mask  (col_mask)
    );

    // Drain handshake: an element transfers on a cycle where out_valid and out_ready are both high;
    // drain_sel only advances on a transfer, so it is stable while out_ready is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            k_len_q        <= '0;
            lat_cnt        <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pe_clear       <= 1'b0;
            pe_en          <= 1'b0;
            precision_mode <= '0;
            step           <= '0;
            row_en         <= '0;
            col_en         <= '0;
            drain_sel      <= '0;
            out_valid      <= 1'b0;
        end else begin
            done     <= 1'b0;
            pe_clear <= 1'b0;
            if (abort && state != IDLE) begin
                state     <= IDLE;
                busy      <= 1'b0;
                pe_en     <= 1'b0;
                step      <= '0;
                row_en    <= '0;
                col_en    <= '0;
                drain_sel <= '0;
                out_valid <= 1'b0;
                lat_cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && k_len != '0) begin
                            state          <= CLEAR;
                            k_len_q        <= k_len;
                            precision_mode <= prec_in;
                            busy           <= 1'b1;
                            pe_clear       <= 1'b1;
                        end
                    end
                    CLEAR: begin
                        state  <= COMPUTE;
                        pe_en  <= 1'b1;
                        step   <= '0;
                        row_en <= row_mask;
                        col_en <= col_mask;
                    end
                    COMPUTE: begin
                        if (step == last_t) begin
                            state   <= WAIT;
                            step    <= '0;
                            row_en  <= '0;
                            col_en  <= '0;
                            lat_cnt <= '0;
                        end else begin
                            step   <= step + STEP_ONE;
                            row_en <= row_mask;
                            col_en <= col_mask;
                        end
                    end
                    WAIT: begin
                        if (lat_cnt == LAT_LAST) begin
                            state     <= DRAIN;
                            pe_en     <= 1'b0;
                            out_valid <= 1'b1;
                            drain_sel <= '0;
                        end else begin
                            lat_cnt <= lat_cnt + LAT_W'(1);
                        end
                    end
                    DRAIN: begin
                        if (out_ready) begin
                            if (drain_sel == SEL_LAST) begin
                                state     <= DONE;
                                out_valid <= 1'b0;
                                drain_sel <= '0;
                                done      <= 1'b1;
                            end else begin
                                drain_sel <= drain_sel + SEL_ONE;
                            end
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pe_array_ctrl.sv
// Bench for pe_array_ctrl: cycle-level reference model, per-cycle compare, drain scoreboard,
// directed scenarios with literal expectations and a randomized phase.
module tb_pe_array_ctrl;

    localparam int M = 2;
    localparam int N = 2;
    localparam int K_WIDTH = 8;
    localparam int PE_LAT = 1;
    localparam int MN = M * N;
    localparam int SEL_W = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [K_WIDTH-1:0] k_len = '0;
    logic [1:0]         prec_in = '0;
    logic               abort = 1'b0;
    logic               out_ready = 1'b1;
    logic               busy, done, pe_clear, pe_en, out_valid;
    logic [1:0]         precision_mode;
    logic [K_WIDTH:0]   step;
    logic [M-1:0]       row_en;
    logic [N-1:0]       col_en;
    logic [SEL_W-1:0]   drain_sel;

    int n_checks = 0;
    int n_fail = 0;
    logic [SEL_W-1:0] exp_q[$];

    logic           tr_busy[0:299], tr_done[0:299], tr_clear[0:299], tr_pe_en[0:299], tr_valid[0:299];
    logic [1:0]     tr_prec[0:299], tr_row[0:299], tr_col[0:299], tr_sel[0:299];
    logic [K_WIDTH:0] tr_step[0:299];

    pe_array_ctrl #(.M(M), .N(N), .K_WIDTH(K_WIDTH), .PE_LAT(PE_LAT), .SEL_W(SEL_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .k_len          (k_len),
        .prec_in        (prec_in),
        .abort          (abort),
        .busy           (busy),
        .done           (done),
        .pe_clear       (pe_clear),
        .pe_en          (pe_en),
        .precision_mode (precision_mode),
        .step           (step),
        .row_en         (row_en),
        .col_en         (col_en),
        .drain_sel      (drain_sel),
        .out_valid      (out_valid),
        .out_ready      (out_ready)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A run is described by the cycle count since it was accepted (m_c) and how many results
    // have been handed over (m_didx); every output follows from those by the timeline rules.
    bit         m_act = 0;
    int         m_c = 0;
    int         m_k = 0;
    int         m_didx = 0;
    logic [1:0] m_prec = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_act = 0; m_c = 0; m_k = 0; m_didx = 0; m_prec = '0;
            exp_q.delete();
        end else if (m_act && abort) begin
            m_act = 0;
            exp_q.delete();
        end else if (!m_act) begin
            if (start && k_len != 0) begin
                m_act = 1; m_c = 1; m_k = int'(k_len); m_prec = prec_in; m_didx = 0;
                exp_q.delete();
                for (int i = 0; i < MN; i++) exp_q.push_back(SEL_W'(i));
            end
        end else if (m_didx == MN) begin
            m_act = 0;
        end else begin
            if (m_c >= 2 + m_k + M + N - 2 + PE_LAT && out_ready) m_didx++;
            m_c++;
        end
    end

    // ---------------- per-cycle compare + drain scoreboard ----------------
    always @(negedge clk) begin
        int         tt;
        int         t_tot;
        logic       e_comp, e_valid;
        logic [M-1:0] e_row;
        logic [N-1:0] e_col;
        logic [31:0]  e_pop;
        t_tot  = m_k + M + N - 2;
        e_comp = m_act && m_c >= 2 && m_c < 2 + t_tot;
        tt     = e_comp ? m_c - 2 : 0;
        for (int i = 0; i < M; i++) e_row[i] = e_comp && tt >= i && tt < i + m_k;
        for (int j = 0; j < N; j++) e_col[j] = e_comp && tt >= j && tt < j + m_k;
        e_valid = m_act && m_c >= 2 + t_tot + PE_LAT && m_didx < MN;
        check("busy", busy, m_act);
        check("done", done, m_act && m_didx == MN);
        check("pe_clear", pe_clear, m_act && m_c == 1);
        check("pe_en", pe_en, m_act && m_c >= 2 && m_c < 2 + t_tot + PE_LAT);
        check("precision_mode", precision_mode, m_prec);
        check("step", step, tt);
        check("row_en", row_en, e_row);
        check("col_en", col_en, e_col);
        check("out_valid", out_valid, e_valid);
        check("drain_sel", drain_sel, e_valid ? m_didx : 0);
        if (!rst && !abort && out_valid && out_ready) begin
            e_pop = (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'hFFFF_FFFF;
            check("drain_order", drain_sel, e_pop);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_start(input logic [K_WIDTH-1:0] k, input logic [1:0] p);
        @(posedge clk); #2;
        start = 1'b1; k_len = k; prec_in = p; abort = 1'b0; out_ready = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    // Records outputs for cycles 1..max_n after the accepting edge; drives backpressure,
    // abort and a stray start at the requested cycles.
    task automatic trace_run(input int max_n, input int bp_from, input int bp_to,
                             input int abort_at, input int start_at, output int done_n);
        done_n = -1;
        for (int n = 1; n <= max_n; n++) begin
            @(negedge clk);
            tr_busy[n] = busy; tr_done[n] = done; tr_clear[n] = pe_clear; tr_pe_en[n] = pe_en;
            tr_prec[n] = precision_mode; tr_step[n] = step; tr_row[n] = row_en; tr_col[n] = col_en;
            tr_sel[n] = drain_sel; tr_valid[n] = out_valid;
            if (done && done_n < 0) done_n = n;
            if (done_n > 0 && n > done_n) break;
            @(posedge clk); #2;
            out_ready = !((n + 1) >= bp_from && (n + 1) <= bp_to);
            abort = (n + 1 == abort_at);
            start = (n + 1 == start_at);
            if (start) begin k_len = 8'd2; prec_in = 2'b11; end
        end
        abort = 1'b0; start = 1'b0; out_ready = 1'b1;
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check("idle_reached", busy, 0);
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        int   dn;
        bit   found;
        logic [7:0] rk;
        logic [1:0] exp_row[0:4];
        exp_row[0] = 2'b01; exp_row[1] = 2'b11; exp_row[2] = 2'b11; exp_row[3] = 2'b10; exp_row[4] = 2'b00;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {busy, done, pe_clear, pe_en, precision_mode, step, row_en, col_en,
                                drain_sel, out_valid}, 0);
        @(posedge clk); #2;
        rst = 1'b0;

        // Normal run
        do_start(8'd3, 2'b01);
        trace_run(20, 0, -1, 0, 0, dn);
        check("norm_done_cycle", dn, 12);
        check("norm_clear_c1", tr_clear[1], 1);
        check("norm_prec_c1", tr_prec[1], 2'b01);
        for (int n = 2; n <= 6; n++) begin
            check("norm_step", tr_step[n], n - 2);
            check("norm_row_en", tr_row[n], exp_row[n - 2]);
            check("norm_col_en", tr_col[n], exp_row[n - 2]);
        end
        check("norm_wait_pe_en", tr_pe_en[7], 1);
        check("norm_wait_row", tr_row[7], 0);
        check("norm_wait_valid", tr_valid[7], 0);
        for (int n = 8; n <= 11; n++) begin
            check("norm_drain_sel", tr_sel[n], n - 8);
            check("norm_drain_valid", tr_valid[n], 1);
            check("norm_drain_pe_en", tr_pe_en[n], 0);
        end
        check("norm_done_prev", tr_done[11], 0);
        check("norm_done_after", tr_done[13], 0);
        check("norm_idle_after", tr_busy[13], 0);
        wait_idle();

        // Backpressure at drain_sel=2 for three cycles
        do_start(8'd3, 2'b01);
        trace_run(30, 10, 12, 0, 0, dn);
        check("bp_done_cycle", dn, 15);
        for (int n = 10; n <= 13; n++) begin
            check("bp_hold_sel", tr_sel[n], 2);
            check("bp_hold_valid", tr_valid[n], 1);
        end
        check("bp_last_sel", tr_sel[14], 3);
        wait_idle();

        // Ignored starts
        do_start(8'd0, 2'b11);
        @(negedge clk);
        check("zero_k_busy", busy, 0);
        check("zero_k_prec", precision_mode, 2'b01);
        do_start(8'd4, 2'b10);
        trace_run(30, 0, -1, 0, 3, dn);
        check("busy_start_done_cycle", dn, 13);
        check("busy_start_prec_c5", tr_prec[5], 2'b10);
        check("busy_start_prec_c13", tr_prec[13], 2'b10);
        check("busy_start_last_step", tr_step[7], 5);
        wait_idle();

        // Abort in cycle 4, then a clean run
        do_start(8'd3, 2'b01);
        trace_run(10, 0, -1, 4, 0, dn);
        check("abort_busy_c4", tr_busy[4], 1);
        check("abort_busy_c5", tr_busy[5], 0);
        check("abort_strobes_c5", {tr_clear[5], tr_pe_en[5], tr_row[5], tr_col[5], tr_valid[5],
                                   tr_done[5], tr_step[5], tr_sel[5]}, 0);
        check("abort_no_done", dn, -1);
        do_start(8'd3, 2'b01);
        trace_run(20, 0, -1, 0, 0, dn);
        check("post_abort_done_cycle", dn, 12);
        wait_idle();

        // Asynchronous reset while draining
        do_start(8'd2, 2'b10);
        found = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (out_valid && drain_sel == 1) begin found = 1; break; end
        end
        check("reach_drain_sel1", found, 1);
        #2 rst = 1'b1;
        #1;
        check("rst_async_outputs", {busy, done, pe_clear, pe_en, precision_mode, step, row_en, col_en,
                                    drain_sel, out_valid}, 0);
        @(posedge clk); #2;
        rst = 1'b0;
        do_start(8'd1, 2'b00);
        trace_run(14, 0, -1, 0, 0, dn);
        check("k1_row_c2", tr_row[2], 2'b01);
        check("k1_row_c3", tr_row[3], 2'b10);
        check("k1_row_c4", tr_row[4], 2'b00);
        check("k1_step_c4", tr_step[4], 2);
        check("k1_wait_c5", {tr_pe_en[5], tr_valid[5]}, 2'b10);
        check("k1_done_cycle", dn, 10);
        wait_idle();

        // Maximum reduction length
        do_start(8'd255, 2'b00);
        trace_run(299, 0, -1, 0, 0, dn);
        check("max_step_255", tr_step[257], 255);
        check("max_step_256", tr_step[258], 256);
        check("max_row_t255", tr_row[257], 2'b10);
        check("max_row_t256", tr_row[258], 2'b00);
        check("max_col_t256", tr_col[258], 2'b00);
        check("max_done_cycle", dn, 264);
        wait_idle();

        // Randomized runs with backpressure, stray starts and occasional abort
        for (int r = 0; r < 25; r++) begin
            rk = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 6));
            do_start(rk, 2'($urandom_range(0, 3)));
            for (int c = 0; c < 200; c++) begin
                @(posedge clk); #2;
                out_ready = ($urandom_range(0, 3) != 0);
                abort = ($urandom_range(0, 49) == 0);
                start = busy && ($urandom_range(0, 9) == 0);
                k_len = 8'($urandom_range(0, 6));
                prec_in = 2'($urandom_range(0, 3));
                if (!busy && c > 1) break;
            end
            start = 1'b0; abort = 1'b0; out_ready = 1'b1;
            check("rand_run_bounded", busy, 0);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
